// File: rtl/pipe_ctrl.sv
// Stall/flush/halt controller for an NSTAGE-deep in-order pipeline of DW-bit latches.
// Define PIPE_PERF_CNT_EN to add the stall_cnt / flush_cnt performance counters.
module pipe_ctrl #(
  parameter int NSTAGE       = 4,
  parameter int DW           = 32,
  parameter int FLUSH_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              mem_req,
  input  logic              flush,
  input  logic              halt_in,
  input  logic [DW-1:0]     in_data,
  output logic              pc_wen,
  output logic [NSTAGE-1:0] stage_en,
  output logic [NSTAGE-1:0] stage_valid,
  output logic [DW-1:0]     out_data,
  output logic              halted
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  // state | meaning
  // RUN   | pipeline advancing normally
  // DWAIT | memory stage waiting on dhit; stages 0..NSTAGE-2 frozen
  // HALT  | halt retired; everything frozen until RST
  typedef enum logic [1:0] {RUN, DWAIT, HALT} state_t;

  localparam logic [NSTAGE-1:0] FLUSH_MASK = NSTAGE'((1 << FLUSH_STAGES) - 1);

  state_t      state;
  logic [DW-1:0] data_q [NSTAGE];
  logic        flush_pend;
  logic        stall;
  logic        halt_req;
  logic        active;
  logic        advance;
  logic        flush_apply;
  logic        load0;

  always_comb begin
    stall       = stage_valid[NSTAGE-2] & mem_req & ~dhit;
    halt_req    = halt_in & stage_valid[NSTAGE-1];
    active      = ~RST & (state != HALT) & ~halt_req;
    advance     = active & ~stall;
    flush_apply = advance & (flush | flush_pend);
    load0       = ihit & ~flush_apply;
    pc_wen      = advance & (ihit | flush_apply);
    if (advance)
      stage_en = '1;
    else if (active)
      stage_en = {1'b1, {(NSTAGE-1){1'b0}}};
    else
      stage_en = '0;
  end

  assign out_data = data_q[NSTAGE-1];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= RUN;
      stage_valid <= '0;
      for (int k = 0; k < NSTAGE; k++) data_q[k] <= '0;
      flush_pend  <= 1'b0;
      halted      <= 1'b0;
`ifdef PIPE_PERF_CNT_EN
      stall_cnt   <= '0;
      flush_cnt   <= '0;
`endif
    end else begin
      case (state)
        RUN, DWAIT: begin
          if (halt_req) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (stall) begin
            // Freeze: last stage drains as a bubble, its payload is kept.
            state                   <= DWAIT;
            stage_valid[NSTAGE-1]   <= 1'b0;
            if (flush) flush_pend   <= 1'b1;
`ifdef PIPE_PERF_CNT_EN
            stall_cnt <= stall_cnt + 32'd1;
`endif
          end else begin
            state      <= RUN;
            flush_pend <= 1'b0;
            for (int k = 1; k < NSTAGE; k++) begin
              data_q[k]      <= data_q[k-1];
              stage_valid[k] <= stage_valid[k-1] & ~(flush_apply & FLUSH_MASK[k]);
            end
            stage_valid[0] <= load0;
            if (load0) data_q[0] <= in_data;
`ifdef PIPE_PERF_CNT_EN
            if (flush_apply) flush_cnt <= flush_cnt + 32'd1;
`endif
          end
        end
        HALT: begin
          halted <= 1'b1;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (NSTAGE=4, FLUSH_STAGES=2).
module tb_pipe_ctrl;

  logic        clk, rst, ihit, dhit, mem_req, flush, halt_in;
  logic [31:0] in_data;
  logic        pc_wen;
  logic [3:0]  stage_en, stage_valid;
  logic [31:0] out_data;
  logic        halted;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int checks;
  int failures;

  pipe_ctrl #(.NSTAGE(4), .DW(32), .FLUSH_STAGES(2)) dut (
    .CLK(clk), .RST(rst), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
    .flush(flush), .halt_in(halt_in), .in_data(in_data), .pc_wen(pc_wen),
    .stage_en(stage_en), .stage_valid(stage_valid), .out_data(out_data),
    .halted(halted)
`ifdef PIPE_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    ihit = 0; dhit = 0; mem_req = 0; flush = 0; halt_in = 0; in_data = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  task automatic fill(input int n);
    for (int i = 1; i <= n; i++) begin
      ihit = 1; in_data = i;
      tick();
    end
    ihit = 0; in_data = '0;
  endtask

  task automatic test_reset();
    idle();
    ihit = 1;
    rst = 1'b1;
    #3;
    checks++; if (stage_valid !== 4'b0000) begin failures++; $display("FAIL reset_valid got=%b exp=0000", stage_valid); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out got=%h exp=0", out_data); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
    checks++; if (pc_wen !== 1'b0) begin failures++; $display("FAIL reset_pc_wen got=%b exp=0", pc_wen); end
    checks++; if (stage_en !== 4'b0000) begin failures++; $display("FAIL reset_stage_en got=%b exp=0000", stage_en); end
    tick();
    checks++; if (stage_valid !== 4'b0000) begin failures++; $display("FAIL reset_hold_valid got=%b exp=0000", stage_valid); end
`ifdef PIPE_PERF_CNT_EN
    checks++; if (stall_cnt !== 0 || flush_cnt !== 0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
`endif
    idle();
    rst = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] tbl [4];
    logic [31:0] exp_out;
    logic        exp_v;
    tbl = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 8; i++) begin
      ihit    = (i < 4);
      in_data = (i < 4) ? tbl[i] : 32'h0;
      #1;
      checks++; if (pc_wen !== (i < 4)) begin failures++; $display("FAIL stream_pc_wen cyc=%0d got=%b exp=%b", i, pc_wen, (i < 4)); end
      checks++; if (stage_en !== 4'hF) begin failures++; $display("FAIL stream_stage_en cyc=%0d got=%b exp=1111", i, stage_en); end
      tick();
      if (i >= 3) begin
        exp_v   = (i <= 6);
        exp_out = (i <= 6) ? tbl[i-3] : 32'h44;
        checks++; if (stage_valid[3] !== exp_v) begin failures++; $display("FAIL stream_valid3 edge=%0d got=%b exp=%b", i+1, stage_valid[3], exp_v); end
        checks++; if (out_data !== exp_out) begin failures++; $display("FAIL stream_out edge=%0d got=%h exp=%h", i+1, out_data, exp_out); end
      end
    end
    idle();
  endtask

  task automatic test_fetch_miss();
    logic [3:0]  pat;
    logic [31:0] dat [4];
    logic [3:0]  expv;
    pat  = 4'b1001;
    expv = 4'b1001;
    dat  = '{32'hA1, 32'h0, 32'h0, 32'hA4};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      ihit    = (i < 4) ? pat[i] : 1'b0;
      in_data = (i < 4) ? dat[i] : 32'h0;
      #1;
      checks++; if (pc_wen !== ihit) begin failures++; $display("FAIL miss_pc_wen cyc=%0d got=%b exp=%b", i, pc_wen, ihit); end
      tick();
      if (i >= 3) begin
        checks++; if (stage_valid[3] !== expv[i-3]) begin failures++; $display("FAIL miss_valid3 edge=%0d got=%b exp=%b", i+1, stage_valid[3], expv[i-3]); end
        if (expv[i-3]) begin
          checks++; if (out_data !== dat[i-3]) begin failures++; $display("FAIL miss_out edge=%0d got=%h exp=%h", i+1, out_data, dat[i-3]); end
        end
      end
    end
    idle();
  endtask

  task automatic test_dwait();
    do_reset();
    fill(3);
    for (int c = 0; c < 3; c++) begin
      mem_req = 1; dhit = 0; ihit = 1; in_data = 32'h99;
      #1;
      checks++; if (pc_wen !== 1'b0) begin failures++; $display("FAIL dwait_pc_wen cyc=%0d got=%b exp=0", c, pc_wen); end
      checks++; if (stage_en !== 4'b1000) begin failures++; $display("FAIL dwait_stage_en cyc=%0d got=%b exp=1000", c, stage_en); end
      tick();
      checks++; if (stage_valid !== 4'b0111) begin failures++; $display("FAIL dwait_valid cyc=%0d got=%b exp=0111", c, stage_valid); end
    end
    dhit = 1;
    #1;
    checks++; if (pc_wen !== 1'b1) begin failures++; $display("FAIL dwait_release_pc_wen got=%b exp=1", pc_wen); end
    checks++; if (stage_en !== 4'hF) begin failures++; $display("FAIL dwait_release_stage_en got=%b exp=1111", stage_en); end
    tick();
    checks++; if (stage_valid !== 4'hF) begin failures++; $display("FAIL dwait_release_valid got=%b exp=1111", stage_valid); end
    checks++; if (out_data !== 32'h1) begin failures++; $display("FAIL dwait_release_out got=%h exp=1", out_data); end
    // mem_req with dhit in the same cycle must not stall
    mem_req = 1; dhit = 1; ihit = 0;
    #1;
    checks++; if (stage_en !== 4'hF) begin failures++; $display("FAIL hit_nostall_stage_en got=%b exp=1111", stage_en); end
    tick();
    checks++; if (out_data !== 32'h2) begin failures++; $display("FAIL hit_nostall_out got=%h exp=2", out_data); end
`ifdef PIPE_PERF_CNT_EN
    checks++; if (stall_cnt !== 32'd3) begin failures++; $display("FAIL dwait_stall_cnt got=%0d exp=3", stall_cnt); end
`endif
    idle();
  endtask

  task automatic test_flush_dwait();
    do_reset();
    fill(3);
    for (int c = 1; c <= 4; c++) begin
      mem_req = 1; ihit = 0; flush = (c == 2); dhit = (c == 4);
      #1;
      if (c < 4) begin
        checks++; if (pc_wen !== 1'b0) begin failures++; $display("FAIL fdw_wait_pc_wen cyc=%0d got=%b exp=0", c, pc_wen); end
      end else begin
        checks++; if (pc_wen !== 1'b1) begin failures++; $display("FAIL fdw_redirect_pc_wen got=%b exp=1", pc_wen); end
      end
      tick();
    end
    checks++; if (stage_valid !== 4'b1100) begin failures++; $display("FAIL fdw_valid got=%b exp=1100", stage_valid); end
    checks++; if (out_data !== 32'h1) begin failures++; $display("FAIL fdw_out got=%h exp=1", out_data); end
`ifdef PIPE_PERF_CNT_EN
    checks++; if (flush_cnt !== 32'd1) begin failures++; $display("FAIL fdw_flush_cnt got=%0d exp=1", flush_cnt); end
    checks++; if (stall_cnt !== 32'd3) begin failures++; $display("FAIL fdw_stall_cnt got=%0d exp=3", stall_cnt); end
`endif
    mem_req = 0; dhit = 0; flush = 0; ihit = 1; in_data = 32'hBB;
    tick();
    checks++; if (stage_valid !== 4'b1001) begin failures++; $display("FAIL fdw_pending_cleared got=%b exp=1001", stage_valid); end
    // flush on a plain advancing cycle, no fetch: redirect still enables PC
    ihit = 0; flush = 1;
    #1;
    checks++; if (pc_wen !== 1'b1) begin failures++; $display("FAIL run_flush_pc_wen got=%b exp=1", pc_wen); end
    tick();
    checks++; if (stage_valid !== 4'b0000) begin failures++; $display("FAIL run_flush_valid got=%b exp=0000", stage_valid); end
`ifdef PIPE_PERF_CNT_EN
    checks++; if (flush_cnt !== 32'd2) begin failures++; $display("FAIL run_flush_cnt got=%0d exp=2", flush_cnt); end
`endif
    idle();
  endtask

  task automatic test_halt();
    do_reset();
    fill(4);
    halt_in = 1; flush = 1; mem_req = 1; dhit = 0; ihit = 1; in_data = 32'h77;
    #1;
    checks++; if (stage_en !== 4'b0000) begin failures++; $display("FAIL halt_req_stage_en got=%b exp=0000", stage_en); end
    checks++; if (pc_wen !== 1'b0) begin failures++; $display("FAIL halt_req_pc_wen got=%b exp=0", pc_wen); end
    tick();
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_halted got=%b exp=1", halted); end
    checks++; if (stage_valid !== 4'hF) begin failures++; $display("FAIL halt_valid got=%b exp=1111", stage_valid); end
    checks++; if (out_data !== 32'h1) begin failures++; $display("FAIL halt_out got=%h exp=1", out_data); end
    halt_in = 0; flush = 0; mem_req = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (pc_wen !== 1'b0 || stage_en !== 4'b0000) begin failures++; $display("FAIL halt_frozen cyc=%0d pc_wen=%b stage_en=%b exp=0/0000", c, pc_wen, stage_en); end
      tick();
      checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_sticky cyc=%0d got=%b exp=1", c, halted); end
    end
`ifdef PIPE_PERF_CNT_EN
    checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL halt_stall_cnt got=%0d exp=0", stall_cnt); end
`endif
    rst = 1'b1;
    #1;
    checks++; if (stage_valid !== 4'b0000 || halted !== 1'b0 || out_data !== 32'h0) begin failures++; $display("FAIL halt_rst valid=%b halted=%b out=%h exp=0000/0/0", stage_valid, halted, out_data); end
    rst = 1'b0;
    ihit = 1; in_data = 32'h5;
    tick();
    checks++; if (stage_valid !== 4'b0001 || halted !== 1'b0) begin failures++; $display("FAIL halt_after_rst valid=%b halted=%b exp=0001/0", stage_valid, halted); end
    idle();
  endtask

  task automatic test_reset_midstream();
    do_reset();
    fill(3);
    mem_req = 1; dhit = 0; flush = 1; ihit = 0;
    tick();
    flush = 0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (stage_valid !== 4'b0000) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0000", stage_valid); end
    checks++; if (out_data !== 32'h0 || halted !== 1'b0) begin failures++; $display("FAIL mid_rst_out out=%h halted=%b exp=0/0", out_data, halted); end
    rst = 1'b0;
    mem_req = 0; ihit = 1; in_data = 32'h7;
    tick();
    checks++; if (stage_valid !== 4'b0001) begin failures++; $display("FAIL mid_rst_no_pending got=%b exp=0001", stage_valid); end
    idle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    idle();
    rst = 1'b1;
    test_reset();
    test_stream();
    test_fetch_miss();
    test_dwait();
    test_flush_dwait();
    test_halt();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter NSTAGE, default 4, number of pipeline latches (legal 2..8).
REQ-002 SHALL have parameter DW, default 32, payload width per stage.
REQ-003 SHALL have parameter FLUSH_STAGES, default 2, number of youngest stages cleared on flush (1..NSTAGE-1).
REQ-004 SHALL have CLK  in  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have RST  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ihit  in  1  instruction fetch returned valid word this cycle.
REQ-007 SHALL have dhit  in  1  data access completed this cycle.
REQ-008 SHALL have mem_req  in  1  instruction in memory stage (index NSTAGE-2) needs a data access.
REQ-009 SHALL have flush  in  1  taken branch/jump, discard younger instructions.
REQ-010 SHALL have halt_in  in  1  instruction in last stage is a halt.
REQ-011 SHALL have in_data  in  DW  fetched payload entering stage 0.
REQ-012 SHALL have pc_wen  out  1  PC update enable.
REQ-013 SHALL have stage_en  out  NSTAGE  per-stage load enable.
REQ-014 SHALL have stage_valid  out  NSTAGE  per-stage valid bit.
REQ-015 SHALL have out_data  out  DW  payload of last stage.
REQ-016 SHALL have halted  out  1  sticky halt indication.

Function
REQ-017 SHALL implement FSM states RUN, DWAIT, HALT.
REQ-018 SHALL define stall = stage_valid[NSTAGE-2] & mem_req & ~dhit.
REQ-019 RUN: stall -> DWAIT; stage_en[0..NSTAGE-2]=0, stage NSTAGE-1 loads bubble (valid 0), pc_wen=0.
REQ-020 RUN, no stall: all stage_en=1, stage k loads stage k-1 (data and valid); stage 0 loads in_data with valid=ihit; pc_wen=ihit.
REQ-021 RUN with ihit=0 and no stall: stage 0 loads bubble, downstream still advances, pc_wen=0.
REQ-022 DWAIT: identical freeze to REQ-019 each cycle until dhit; dhit -> RUN and full advance in that same cycle (zero added latency).
REQ-023 mem_req & dhit in same cycle SHALL not stall.
REQ-024 flush on an advancing cycle SHALL load valid=0 into stages 0..FLUSH_STAGES-1 (in_data ignored) and force pc_wen=1 for redirect.
REQ-025 flush during DWAIT SHALL be latched as pending and applied on the first advancing cycle; second flush while pending SHALL merge.
REQ-026 halt_in with stage_valid[NSTAGE-1]=1 SHALL move to HALT next edge; HALT has priority over stall and flush.
REQ-027 HALT: stage_en=0, pc_wen=0, halted=1, state held until RST.
REQ-028 Latency: payload captured at stage 0 appears on out_data after NSTAGE advancing cycles.
REQ-029 Payload of invalid stages SHALL be held, not zeroed; consumers qualify with stage_valid.

Reset
REQ-030 RST SHALL asynchronously force state RUN, all stage_valid=0, all payloads 0, pending flush 0, halted=0.
REQ-031 During RST pc_wen=0 and stage_en=0; first edge after RST release SHALL behave per RUN.
REQ-032 RST mid-DWAIT or mid-HALT SHALL discard all in-flight stages with no residual pending flush.

Configuration
REQ-033 Macro PIPE_PERF_CNT_EN SHALL, when defined, add outputs stall_cnt[31:0] (increments each cycle in DWAIT or REQ-019 freeze) and flush_cnt[31:0] (increments per applied flush), both wrapping at 2^32, cleared by RST, frozen in HALT.
REQ-034 Without PIPE_PERF_CNT_EN the counters and their ports SHALL not exist; all other behaviour identical.

Verification
REQ-035 Reset: RST=1 mid-stream -> all stage_valid=0, out_data=0, halted=0 immediately (before edge).
REQ-036 Stream: ihit=1, in_data=0x11,0x22,0x33,0x44, NSTAGE=4 -> out_data=0x11 with stage_valid[3]=1 on 4th edge, then 0x22, 0x33, 0x44.
REQ-037 Data wait: mem_req=1, dhit=0 for 3 cycles -> stages 0..2 frozen, stage_valid[3]=0, pc_wen=0 for 3 cycles; dhit=1 -> advance same cycle.
REQ-038 Flush during DWAIT: flush pulse in cycle 2 of wait, dhit in cycle 4 -> on that advance stage_valid[1:0]=00, pc_wen=1, flush_cnt=1 when PIPE_PERF_CNT_EN.
REQ-039 Halt: halt_in=1 with stage_valid[3]=1 plus simultaneous flush and stall -> HALT next edge, halted=1, pc_wen=0 until RST.
REQ-040 Fetch miss: ihit=0 for 2 cycles in RUN -> two bubbles enter stage 0, older instructions still reach out_data on schedule.
